// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a length-prefixed program image over UART and
// writes it into program RAM from address 0, holding the CPU in reset until
// the whole image has arrived.
// Optional feature macro: UART_BOOT_CHECKSUM_EN adds a trailing modulo-256
// checksum byte that must match the payload before the CPU is released.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 10,
  parameter int TIMEOUT_CLKS = 1200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        reload,
  output logic [7:0]  mem_din,
  output logic [15:0] mem_addr,
  output logic        mem_write,
  output logic        mem_read,
  output logic        bus_own,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    PAYLOAD,
`ifdef UART_BOOT_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      rx_byte;
  logic            byte_valid;
  logic            frame_err;

  state_t          state;
  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [ADDR_W:0] cnt;
  logic [TW-1:0]   tout_cnt;
  logic [15:0]     new_len;
  logic [16:0]     cnt_inc_ext;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]      sum;
`endif

  assign new_len     = {len_hi, rx_byte};
  assign cnt_inc_ext = 17'(cnt) + 17'd1;
  assign mem_read    = 1'b0;

  // Two-flop synchroniser for the asynchronous rx line plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // UART receiver: start-bit qualification, mid-bit data sampling and stop-bit check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Load sequencer: length header, payload writes, optional checksum, then hand the bus to the CPU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LEN_HI;
      mem_din   <= '0;
      mem_addr  <= '0;
      mem_write <= 1'b0;
      bus_own   <= 1'b1;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      len_hi    <= '0;
      len       <= '0;
      cnt       <= '0;
      tout_cnt  <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_write <= 1'b0;
      case (state)
        LEN_HI: begin
          if (frame_err) begin
            err <= 1'b1;
          end else if (byte_valid) begin
            len_hi <= rx_byte;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (frame_err) begin
            err   <= 1'b1;
            state <= LEN_HI;
          end else if (byte_valid) begin
            len      <= new_len;
            cnt      <= '0;
            tout_cnt <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
            sum      <= '0;
`endif
            if (new_len == 16'd0) begin
`ifdef UART_BOOT_CHECKSUM_EN
              state <= CHECK;
`else
              state    <= DONE;
              done     <= 1'b1;
              bus_own  <= 1'b0;
              mem_addr <= '0;
`endif
            end else if ({1'b0, new_len} > MAX_LEN) begin
              err   <= 1'b1;
              state <= LEN_HI;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (frame_err) begin
            err   <= 1'b1;
            state <= LEN_HI;
          end else if (!byte_valid && tout_cnt == TW'(TIMEOUT_CLKS - 1)) begin
            err   <= 1'b1;
            state <= LEN_HI;
          end else begin
            tout_cnt <= byte_valid ? '0 : tout_cnt + TW'(1);
            if (byte_valid) begin
              mem_write <= 1'b1;
              mem_din   <= rx_byte;
              mem_addr  <= 16'(cnt[ADDR_W-1:0]);
`ifdef UART_BOOT_CHECKSUM_EN
              sum       <= sum + rx_byte;
`endif
            end
            if (mem_write) begin
              cnt <= cnt + 1'b1;
              if (cnt_inc_ext == {1'b0, len}) begin
`ifdef UART_BOOT_CHECKSUM_EN
                state <= CHECK;
`else
                state    <= DONE;
                done     <= 1'b1;
                bus_own  <= 1'b0;
                mem_addr <= '0;
`endif
              end
            end
          end
        end
`ifdef UART_BOOT_CHECKSUM_EN
        CHECK: begin
          if (frame_err) begin
            err   <= 1'b1;
            state <= LEN_HI;
          end else if (byte_valid) begin
            if (rx_byte == sum) begin
              state    <= DONE;
              done     <= 1'b1;
              bus_own  <= 1'b0;
              mem_addr <= '0;
            end else begin
              err   <= 1'b1;
              state <= LEN_HI;
            end
          end
        end
`endif
        DONE: begin
          if (reload) begin
            cpu_hold <= 1'b1;
            bus_own  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            state    <= LEN_HI;
          end else if (done) begin
            cpu_hold <= 1'b0;
          end
        end
        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: table of load scenarios, hand-written
// framing/reset sequences, and randomized images checked against a simple
// "byte i lands at address i" reference model.
module tb_uart_boot_loader;

  localparam int CPB  = 4;
  localparam int AW   = 10;
  localparam int TOUT = 200;
`ifdef UART_BOOT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        reload = 1'b0;
  logic [7:0]  mem_din;
  logic [15:0] mem_addr;
  logic        mem_write;
  logic        mem_read;
  logic        bus_own;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [15:0] capAddr[$];
  logic [7:0]  capData[$];
  logic [15:0] expAddr[$];
  logic [7:0]  expData[$];
  logic        prevWrite = 1'b0;
  logic [7:0]  payBuf[64];

  typedef struct {
    logic [15:0] len;
    int          nPay;
    logic [31:0] pay;
    bit          doReload;
    bit          waitTimeout;
    bit          expDone;
    bit          expErr;
  } vec_t;

  vec_t vecs[5];

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W(AW),
    .TIMEOUT_CLKS(TOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .reload(reload),
    .mem_din(mem_din),
    .mem_addr(mem_addr),
    .mem_write(mem_write),
    .mem_read(mem_read),
    .bus_own(bus_own),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Capture every RAM write and make sure each strobe is exactly one clock wide
  always @(negedge clk) begin
    if (prevWrite) begin
      checks++;
      if (mem_write) begin
        failures++;
        $display("[TB] FAIL write_width actual=2+ clocks expected=1 clock at addr %0h", mem_addr);
      end
    end
    if (mem_write) begin
      capAddr.push_back(mem_addr);
      capData.push_back(mem_din);
    end
    prevWrite = mem_write;
  end

  // Safety net so a stuck DUT can never hang the run
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stopBit) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic clearQueues();
    capAddr.delete();
    capData.delete();
    expAddr.delete();
    expData.delete();
  endtask

  // Send header, n payload bytes from payBuf and, when enabled, the checksum; build expected writes
  task automatic applyStimulus(input logic [15:0] len, input int n, input logic [7:0] csumXor,
                               input int maxGapBits);
    logic [7:0] s;
    s = 8'h00;
    sendByte(len[15:8], 1'b1);
    repeat ($urandom_range(0, maxGapBits) * CPB) @(negedge clk);
    sendByte(len[7:0], 1'b1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxGapBits) * CPB) @(negedge clk);
      sendByte(payBuf[i], 1'b1);
      s = s + payBuf[i];
      if (len <= 16'(2 ** AW) && i < int'(len)) begin
        expAddr.push_back(16'(i));
        expData.push_back(payBuf[i]);
      end
    end
    if (CSUM_EN && n == int'(len) && len <= 16'(2 ** AW)) sendByte(s ^ csumXor, 1'b1);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, "_wr_count"}, 32'(capAddr.size()), 32'(expAddr.size()));
    for (int i = 0; i < capAddr.size() && i < expAddr.size(); i++) begin
      checkOutput({tag, "_wr_addr"}, 32'(capAddr[i]), 32'(expAddr[i]));
      checkOutput({tag, "_wr_data"}, 32'(capData[i]), 32'(expData[i]));
    end
  endtask

  task automatic waitDone(input string tag, input int maxCyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput({tag, "_done_rise"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_hold_at_done"}, 32'(cpu_hold), 32'd1);
      @(negedge clk);
      checkOutput({tag, "_hold_release"}, 32'(cpu_hold), 32'd0);
      checkOutput({tag, "_bus_release"}, 32'(bus_own), 32'd0);
      checkOutput({tag, "_addr_idle"}, 32'(mem_addr), 32'd0);
    end
  endtask

  task automatic waitErr(input string tag, input int maxCyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge clk);
      if (err) seen = 1'b1;
    end
    checkOutput({tag, "_err_rise"}, 32'(seen), 32'd1);
  endtask

  task automatic doReload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("reload_hold", 32'(cpu_hold), 32'd1);
    checkOutput("reload_bus", 32'(bus_own), 32'd1);
    checkOutput("reload_done", 32'(done), 32'd0);
    checkOutput("reload_err", 32'(err), 32'd0);
    clearQueues();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_din"}, 32'(mem_din), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_write"}, 32'(mem_write), 32'd0);
    checkOutput({tag, "_read"}, 32'(mem_read), 32'd0);
    checkOutput({tag, "_bus"}, 32'(bus_own), 32'd1);
    checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [15:0] rlen;

    vecs[0] = '{len: 16'h0003, nPay: 3, pay: 32'h00C3B2A1, doReload: 1'b0, waitTimeout: 1'b0, expDone: 1'b1, expErr: 1'b0};
    vecs[1] = '{len: 16'h0000, nPay: 0, pay: 32'h0, doReload: 1'b1, waitTimeout: 1'b0, expDone: 1'b1, expErr: 1'b0};
    vecs[2] = '{len: 16'h0401, nPay: 0, pay: 32'h0, doReload: 1'b1, waitTimeout: 1'b0, expDone: 1'b0, expErr: 1'b1};
    vecs[3] = '{len: 16'h0001, nPay: 1, pay: 32'h0000005A, doReload: 1'b0, waitTimeout: 1'b0, expDone: 1'b1, expErr: 1'b1};
    vecs[4] = '{len: 16'h0004, nPay: 2, pay: 32'h00002211, doReload: 1'b1, waitTimeout: 1'b1, expDone: 1'b0, expErr: 1'b1};

    repeat (3) @(negedge clk);
    checkResetValues("in_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("after_reset");

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      if (vecs[v].doReload) doReload();
      else clearQueues();
      for (int i = 0; i < 4; i++) payBuf[i] = vecs[v].pay[8*i +: 8];
      applyStimulus(vecs[v].len, vecs[v].nPay, 8'h00, 0);
      if (vecs[v].expDone) waitDone(tag, 100);
      else if (vecs[v].waitTimeout) waitErr(tag, TOUT + 100);
      else repeat (20) @(negedge clk);
      checkOutput({tag, "_done"}, 32'(done), 32'(vecs[v].expDone));
      checkOutput({tag, "_err"}, 32'(err), 32'(vecs[v].expErr));
      checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'(!vecs[v].expDone));
      checkOutput({tag, "_bus"}, 32'(bus_own), 32'(!vecs[v].expDone));
      checkWrites(tag);
    end

    // Framing error on the first length byte: flagged and discarded
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearQueues();
    sendByte(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("frame_err", 32'(err), 32'd1);
    checkOutput("frame_hold", 32'(cpu_hold), 32'd1);
    payBuf[0] = 8'h66;
    applyStimulus(16'h0001, 1, 8'h00, 0);
    waitDone("frame_next", 100);
    checkWrites("frame_next");

    // Asynchronous reset in the middle of a payload byte
    doReload();
    payBuf[0] = 8'h99;
    payBuf[1] = 8'h98;
    sendByte(8'h00, 1'b1);
    sendByte(8'h05, 1'b1);
    sendByte(8'h99, 1'b1);
    sendByte(8'h98, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("mid_addr", 32'(mem_addr), 32'd1);
    checkOutput("mid_din", 32'(mem_din), 32'h98);
    rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    clearQueues();
    payBuf[0] = 8'h77;
    applyStimulus(16'h0001, 1, 8'h00, 0);
    waitDone("post_reset", 100);
    checkOutput("post_reset_err", 32'(err), 32'd0);
    checkWrites("post_reset");

`ifdef UART_BOOT_CHECKSUM_EN
    // Checksum good, then checksum off by one
    doReload();
    payBuf[0] = 8'h10;
    payBuf[1] = 8'h20;
    applyStimulus(16'h0002, 2, 8'h00, 0);
    waitDone("csum_ok", 100);
    checkOutput("csum_ok_err", 32'(err), 32'd0);
    doReload();
    applyStimulus(16'h0002, 2, 8'h01, 0);
    repeat (20) @(negedge clk);
    checkOutput("csum_bad_err", 32'(err), 32'd1);
    checkOutput("csum_bad_hold", 32'(cpu_hold), 32'd1);
    checkOutput("csum_bad_done", 32'(done), 32'd0);
    doReload();
    payBuf[0] = 8'h01;
    applyStimulus(16'h0001, 1, 8'h00, 0);
    waitDone("csum_recover", 100);
`endif

    // Randomized images with random inter-byte gaps
    for (int r = 0; r < 6; r++) begin
      string tag;
      tag = $sformatf("rand%0d", r);
      doReload();
      rlen = 16'($urandom_range(1, 16));
      for (int i = 0; i < int'(rlen); i++) payBuf[i] = 8'($urandom);
      applyStimulus(rlen, int'(rlen), 8'h00, 3);
      waitDone(tag, 100);
      checkOutput({tag, "_err"}, 32'(err), 32'd0);
      checkWrites(tag);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
